// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters.
// A {valid,id} tag pipeline tracks the multiplier latency and freezes with it under backpressure.
module mult_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int MULT_LATENCY = 3,
    parameter int ID_WIDTH     = 2
) (
    input  logic                          Clock,
    input  logic                          Aclr,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         MulDataA,
    output logic [DATA_WIDTH-1:0]         MulDataB,
    output logic                          MulClkEn,
    input  logic [2*DATA_WIDTH-1:0]       MulResult,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    input  logic                          rsp_ready,
    output logic                          busy
);

    logic                  stall;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   scan_id;
    logic                  handshake;
    logic [ID_WIDTH-1:0]   ptr_reg;
    logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] op_b [NUM_REQ];
    logic                  tag_valid_reg [MULT_LATENCY];
    logic [ID_WIDTH-1:0]   tag_id_reg    [MULT_LATENCY];
    logic                  tag_valid_in  [MULT_LATENCY];
    logic [ID_WIDTH-1:0]   tag_id_in     [MULT_LATENCY];

    assign stall    = rsp_valid & ~rsp_ready;
    assign MulClkEn = ~stall;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi]      = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign op_b[gi]      = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = handshake && (grant_id == ID_WIDTH'(gi));
        end
    endgenerate

    // Scan starts one past the last granted requester, so the winner drops to lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_id = ID_WIDTH'((int'(ptr_reg) + off) % NUM_REQ);
            if (!grant_found && req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Aclr gating keeps req_ready low for the whole reset pulse, not just after the next edge.
    assign handshake = grant_found & ~stall & ~Aclr;
    assign MulDataA  = handshake ? op_a[grant_id] : '0;
    assign MulDataB  = handshake ? op_b[grant_id] : '0;

    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            ptr_reg <= ID_WIDTH'(NUM_REQ - 1);
        end else if (handshake) begin
            ptr_reg <= grant_id;
        end
    end

    generate
        for (genvar gi = 0; gi < MULT_LATENCY; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_in[gi] = handshake;
                assign tag_id_in[gi]    = grant_id;
            end else begin : g_body
                assign tag_valid_in[gi] = tag_valid_reg[gi-1];
                assign tag_id_in[gi]    = tag_id_reg[gi-1];
            end

            always_ff @(posedge Clock or posedge Aclr) begin
                if (Aclr) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else if (MulClkEn) begin
                    tag_valid_reg[gi] <= tag_valid_in[gi];
                    tag_id_reg[gi]    <= tag_id_in[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MULT_LATENCY; s++) begin
            busy = busy | tag_valid_reg[s];
        end
    end

    assign rsp_valid = tag_valid_reg[MULT_LATENCY-1];
    assign rsp_id    = tag_id_reg[MULT_LATENCY-1];
    assign rsp_data  = MulResult;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural 3-stage signed multiplier attached.
module tb_mult_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 12;

    logic              Clock = 1'b0;
    logic              Aclr;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR-1:0]     req_ready;
    logic [DW-1:0]     MulDataA;
    logic [DW-1:0]     MulDataB;
    logic              MulClkEn;
    logic [2*DW-1:0]   MulResult;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [2*DW-1:0]   rsp_data;
    logic              rsp_ready;
    logic              busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int rsp_count;

    mult_share_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MULT_LATENCY(3), .ID_WIDTH(2)
    ) dut (
        .Clock(Clock), .Aclr(Aclr),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .MulDataA(MulDataA), .MulDataB(MulDataB), .MulClkEn(MulClkEn), .MulResult(MulResult),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Input register, product register, output register; all frozen by ClkEn.
    logic signed [DW-1:0]   mul_a_r, mul_b_r;
    logic signed [2*DW-1:0] mul_p1, mul_p2;
    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            mul_a_r <= '0;
            mul_b_r <= '0;
            mul_p1  <= '0;
            mul_p2  <= '0;
        end else if (MulClkEn) begin
            mul_a_r <= MulDataA;
            mul_b_r <= MulDataB;
            mul_p1  <= mul_a_r * mul_b_r;
            mul_p2  <= mul_p1;
        end
    end
    assign MulResult = mul_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        Aclr = 1'b1;
        tick();
        Aclr = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Aclr      = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0001;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        Aclr      = 1'b0;
        req_valid = '0;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Single request, -2048 * -2048
        set_op(0, 12'h800, 12'h800);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_opa", 32'(MulDataA), 32'h800);
        tick();
        req_valid = '0;
        #1;
        chk("single_busy", 32'(busy), 32'h1);
        chk("idle_opa_zero", 32'(MulDataA), 32'h0);
        tick();
        chk("single_not_yet", 32'(rsp_valid), 32'h0);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_id", 32'(rsp_id), 32'h0);
        chk("single_data", 32'(rsp_data), 32'h400000);
        tick();
        chk("single_done_valid", 32'(rsp_valid), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);

        // All requesters continuously valid: a=i+1, b=100
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), 12'd100);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 3) begin
                chk($sformatf("rr_valid%0d", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'((k - 3) % 4));
                chk($sformatf("rr_data%0d", k), 32'(rsp_data), 32'(100 * ((k - 3) % 4 + 1)));
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_tail_id1", 32'(rsp_id), 32'h1);
        chk("rr_tail_d200", 32'(rsp_data), 32'd200);
        tick();
        chk("rr_tail_id2", 32'(rsp_id), 32'h2);
        chk("rr_tail_d300", 32'(rsp_data), 32'd300);
        tick();
        chk("rr_tail_id3", 32'(rsp_id), 32'h3);
        chk("rr_tail_d400", 32'(rsp_data), 32'd400);
        tick();
        chk("rr_drained_valid", 32'(rsp_valid), 32'h0);
        chk("rr_drained_busy", 32'(busy), 32'h0);

        // Backpressure on a stream from requester 1, 2047*2047
        set_op(1, 12'h7FF, 12'h7FF);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        tick();
        rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_data%0d", k), 32'(rsp_data), 32'd4190209);
            chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'h1);
            chk($sformatf("bp_clken%0d", k), 32'(MulClkEn), 32'h0);
            chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        rsp_count = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) begin
                rsp_count++;
                chk($sformatf("bp_rel_data%0d", k), 32'(rsp_data), 32'd4190209);
            end
            tick();
        end
        chk("bp_rsp_count", 32'(rsp_count), 32'd3);
        chk("bp_busy_after", 32'(busy), 32'h0);

        // Fairness: requester 0 always valid, requester 2 once
        do_reset();
        set_op(0, 12'd3, 12'd5);
        set_op(2, 12'd7, 12'd9);
        req_valid = 4'b0001;
        #1;
        chk("fair_first0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0101;
        #1;
        chk("fair_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("fair_wrap0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();
        chk("fair_busy", 32'(busy), 32'h0);

        // Reset with operations in flight
        do_reset();
        req_valid = 4'b0111;
        #1;
        tick();
        tick();
        tick();
        chk("rst_busy_before", 32'(busy), 32'h1);
        Aclr = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        Aclr      = 1'b0;
        req_valid = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_quiet%0d", k), 32'(rsp_valid), 32'h0);
            tick();
        end

        // Mixed signs from requester 3, back to back
        set_op(3, 12'hFFF, 12'h7FF);
        req_valid = 4'b1000;
        #1;
        chk("mix_grant3", 32'(req_ready), 32'h8);
        chk("mix_opa", 32'(MulDataA), 32'hFFF);
        tick();
        set_op(3, 12'h800, 12'h7FF);
        #1;
        tick();
        req_valid = '0;
        #1;
        chk("mix_not_yet", 32'(rsp_valid), 32'h0);
        tick();
        chk("mix1_valid", 32'(rsp_valid), 32'h1);
        chk("mix1_id", 32'(rsp_id), 32'h3);
        chk("mix1_data", 32'(rsp_data), 32'hFFF801);
        tick();
        chk("mix2_valid", 32'(rsp_valid), 32'h1);
        chk("mix2_data", 32'(rsp_data), 32'hC00800);
        tick();
        chk("mix_end_valid", 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin scheduler that shares one pipelined signed multiplier (12x12, registered inputs, pipeline and output stages, 3 enabled clocks of latency) among NUM_REQ requesters, e.g. the I/Q mixer and FIR paths of the SDR chain.
- Grants at most one operand pair per cycle and drives the multiplier's ClkEn.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency, and returns each product tagged with the requester index.
- Freezes the whole multiplier pipeline when the consumer applies backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 12, signed operand width; the product is 2*DATA_WIDTH.
- MULT_LATENCY, 3, ClkEn-enabled edges from operand sample to product valid at multiplier output.
- ID_WIDTH, 2, width of the requester index; must be at least clog2(NUM_REQ).

Ports:
- Clock, in, 1, system clock shared with the multiplier.
- Aclr, in, 1, asynchronous active-high reset, also wired to the multiplier Aclr.
- req_valid, in, NUM_REQ, per-requester operand valid.
- req_a, in, NUM_REQ*DATA_WIDTH, packed signed operand A; slice i belongs to requester i.
- req_b, in, NUM_REQ*DATA_WIDTH, packed signed operand B.
- req_ready, out, NUM_REQ, one-hot grant; a handshake occurs when req_valid[i]&req_ready[i].
- MulDataA, out, DATA_WIDTH, operand A to the multiplier.
- MulDataB, out, DATA_WIDTH, operand B to the multiplier.
- MulClkEn, out, 1, multiplier clock enable.
- MulResult, in, 2*DATA_WIDTH, multiplier product.
- rsp_valid, out, 1, product valid.
- rsp_id, out, ID_WIDTH, requester index of the product.
- rsp_data, out, 2*DATA_WIDTH, signed product (equals MulResult).
- rsp_ready, in, 1, consumer accepts the product.
- busy, out, 1, at least one operation in flight.

Behaviour:
- Reset (Aclr=1, async):
  - Tag pipeline valid bits: 0.
  - RR pointer: NUM_REQ-1, so requester 0 has highest priority first.
  - rsp_valid=0, busy=0, req_ready=0 while Aclr is high.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - MulClkEn = ~stall (combinational).
  - While stalled: the tag pipeline holds, req_ready=0, and the multiplier holds all registers, so rsp_data and rsp_id stay stable.
- Arbitration (combinational):
  - Scan requesters starting at pointer+1 modulo NUM_REQ; grant the first with req_valid=1.
  - req_ready = grant & ~stall.
  - The pointer updates to the granted index only on a completed handshake; with no handshake it holds.
- Operands:
  - MulDataA/MulDataB = operand slices of the granted requester.
  - Drive all zeros when there is no grant or when stalled.
- Tag pipeline:
  - MULT_LATENCY stages of {valid, id}; shifts on edges where MulClkEn=1.
  - Stage 0 loads {handshake, granted id}.
  - rsp_valid/rsp_id = last stage.
  - An idle cycle inserts a bubble (valid=0).
- Latency: the product for a handshake at edge N appears on rsp_* after edge N+MULT_LATENCY-1, i.e. visible MULT_LATENCY cycles after req_ready is sampled, assuming no stall. Each stall cycle adds one cycle.
- Throughput: 1 product per cycle when rsp_ready=1.
- Stall timing: a stall beginning in the same cycle a new request is valid suppresses that grant; the request waits and is not lost.
- busy = OR of all tag valid bits.
- Arithmetic: signed two's complement, full 2*DATA_WIDTH product; no rounding or truncation.
- Reset mid-operation discards all in-flight tags. The multiplier is cleared by the same Aclr; no stale rsp_valid appears after release.
- ID ordering: products return strictly in grant order.

Test Plan:
- Single request: req 0, a=-2048, b=-2048 -> after 3 cycles rsp_valid=1, rsp_id=0, rsp_data=24'h400000. Next cycle busy=0.
- All 4 requesters valid continuously, req i with a=i+1, b=100 -> grants 0,1,2,3,0,... one per cycle. Responses ids 0,1,2,3 with data 100,200,300,400, back-to-back.
- Backpressure: stream from req 1 (a=2047, b=2047) with rsp_ready=0 for 5 cycles when the first response appears -> rsp_data holds 4190209, MulClkEn=0, req_ready=0 for 5 cycles. No products are lost or duplicated after release.
- Fairness: req 0 always valid, req 2 asserts once -> req 2 is granted within 2 cycles, and the pointer then resumes at 3 (wraps to 0).
- Reset mid-flight: 3 operations in flight, pulse Aclr for 1 cycle asynchronously -> rsp_valid=0 and busy=0 immediately. No responses after release until new requests are issued.
- Mixed signs: a=-1, b=2047 -> rsp_data=24'hFFF801. a=-2048, b=2047 -> 24'hC00800.
